// File: rtl/transmissor_medida_if.sv
// Handshake bundle between the sonar control/datapath, the frame formatter and the UART core.
interface transmissor_medida_if;
    logic        transmitir;
    logic [2:0]  posicao;
    logic [11:0] medida;
    logic        tx_pronto;
    logic        tx_partida;
    logic [6:0]  tx_dados;
    logic        fim_transmissao;
    logic        ocupado;
    logic [3:0]  db_estado;

    modport master (
        output transmitir, posicao, medida, tx_pronto,
        input  tx_partida, tx_dados, fim_transmissao, ocupado, db_estado
    );

    modport slave (
        input  transmitir, posicao, medida, tx_pronto,
        output tx_partida, tx_dados, fim_transmissao, ocupado, db_estado
    );
endinterface

// File: rtl/transmissor_medida.sv
// Formats one sonar sample as the 8-char ASCII frame "aaa,ddd#" and feeds it to the UART
// one character at a time.
module transmissor_medida (
    input  logic                   clock,
    input  logic                   reset,
    transmissor_medida_if.slave    bus
);
    localparam int unsigned IDX_W = 3;
    localparam int unsigned POS_W = 3;
    localparam int unsigned MED_W = 12;
    localparam int unsigned CHR_W = 7;

    localparam logic [CHR_W-1:0] CHAR_SEP  = 7'h2C;
    localparam logic [CHR_W-1:0] CHAR_FIM  = 7'h23;
    localparam logic [CHR_W-1:0] CHAR_ERRO = 7'h3F;
    localparam logic [CHR_W-1:0] CHAR_ZERO = 7'h30;

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        PREPARA = 4'h1,
        ENVIA   = 4'h2,
        ESPERA  = 4'h3,
        PROXIMO = 4'h4,
        FINAL   = 4'hF
    } estado_t;

    estado_t            estado, estado_prox;
    logic [POS_W-1:0]   pos_reg, pos_prox;
    logic [MED_W-1:0]   med_reg, med_prox;
    logic [IDX_W-1:0]   idx, idx_prox;

    // One BCD digit to ASCII; non-decimal nibbles become '?'
    function automatic logic [CHR_W-1:0] ascii_digito(input logic [3:0] d);
        logic [CHR_W-1:0] c;
        if (d <= 4'd9) c = CHAR_ZERO + CHR_W'(d);
        else           c = CHAR_ERRO;
        return c;
    endfunction

    // Servo position index to angle in BCD (20 degrees per step, starting at 20)
    function automatic logic [11:0] angulo_bcd(input logic [POS_W-1:0] p);
        logic [11:0] a;
        case (p)
            3'd0:    a = 12'h020;
            3'd1:    a = 12'h040;
            3'd2:    a = 12'h060;
            3'd3:    a = 12'h080;
            3'd4:    a = 12'h100;
            3'd5:    a = 12'h120;
            3'd6:    a = 12'h140;
            default: a = 12'h160;
        endcase
        return a;
    endfunction

    function automatic logic [CHR_W-1:0] caractere(input logic [POS_W-1:0] p,
                                                    input logic [MED_W-1:0] m,
                                                    input logic [IDX_W-1:0] i);
        logic [11:0]      a;
        logic [CHR_W-1:0] c;
        a = angulo_bcd(p);
        case (i)
            3'd0:    c = ascii_digito(a[11:8]);
            3'd1:    c = ascii_digito(a[7:4]);
            3'd2:    c = ascii_digito(a[3:0]);
            3'd3:    c = CHAR_SEP;
            3'd4:    c = ascii_digito(m[11:8]);
            3'd5:    c = ascii_digito(m[7:4]);
            3'd6:    c = ascii_digito(m[3:0]);
            default: c = CHAR_FIM;
        endcase
        return c;
    endfunction

    // Next-state and next-datapath values; outputs are registered from these
    always_comb begin
        estado_prox = estado;
        pos_prox    = pos_reg;
        med_prox    = med_reg;
        idx_prox    = idx;
        case (estado)
            INICIAL: if (bus.transmitir) estado_prox = PREPARA;
            PREPARA: begin
                pos_prox    = bus.posicao;
                med_prox    = bus.medida;
                idx_prox    = '0;
                estado_prox = ENVIA;
            end
            ENVIA:   estado_prox = ESPERA;
            ESPERA:  if (bus.tx_pronto) estado_prox = PROXIMO;
            PROXIMO: begin
                if (idx == IDX_W'(7)) begin
                    estado_prox = FINAL;
                end else begin
                    idx_prox    = idx + IDX_W'(1);
                    estado_prox = ENVIA;
                end
            end
            FINAL:   estado_prox = INICIAL;
            default: estado_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado              <= INICIAL;
            pos_reg             <= '0;
            med_reg             <= '0;
            idx                 <= '0;
            bus.tx_partida      <= 1'b0;
            bus.fim_transmissao <= 1'b0;
            bus.ocupado         <= 1'b0;
            bus.db_estado       <= 4'h0;
            bus.tx_dados        <= CHAR_ZERO;
        end else begin
            estado              <= estado_prox;
            pos_reg             <= pos_prox;
            med_reg             <= med_prox;
            idx                 <= idx_prox;
            bus.tx_partida      <= (estado_prox == ENVIA);
            bus.fim_transmissao <= (estado_prox == FINAL);
            bus.ocupado         <= (estado_prox != INICIAL);
            bus.db_estado       <= 4'(estado_prox);
            bus.tx_dados        <= caractere(pos_prox, med_prox, idx_prox);
        end
    end
endmodule
